dff_rr_writer: RTL

Round-robin write arbiter that shares one WIDTH-bit storage register, built from Dff instances, between N requesters. Each cycle, at most one requester's data is granted and loaded into the register. The block also tracks which requester wrote last, pulses an update strobe and counts accepted writes. It sits between several producer blocks and a single shared configuration/state register.

---
 rtl/dff_rr_pkg.sv | 14 +
 rtl/dff.sv | 18 +
 rtl/dff_rr_writer_rr_grant.sv | 41 ++++
 rtl/dff_rr_writer.sv | 88 ++++++++
 4 files changed

// File: rtl/dff_rr_pkg.sv
// Shared helpers for the round-robin register writer.
// Index width, reset default and index typedefs.
package dff_rr_pkg;

  localparam int DEFAULT_RESET_VAL = 0;
  localparam int MAX_IDX_W = 4;

  typedef logic [MAX_IDX_W-1:0] idx_max_t;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff.sv
// Plain storage register with async active-low reset.
// Write-enable logic lives in front of d.
module Dff #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= RESET_VAL;
    else      q <= d;
  end

endmodule

// File: rtl/dff_rr_writer_rr_grant.sv
// Combinational rotate-priority-rotate one-hot arbiter.
// Lowest valid index at or above ptr (mod N) wins.
module rr_grant
  import dff_rr_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic [N-1:0] rot;
  int           sel;
  int           idx;

  always_comb begin
    rot       = '0;
    grant     = '0;
    grant_idx = '0;
    sel       = 0;
    idx       = 0;
    for (int j = 0; j < N; j++) begin
      idx    = j + int'(ptr);
      if (idx >= N) idx = idx - N;
      rot[j] = valid[idx];
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) sel = k;
    end
    idx = sel + int'(ptr);
    if (idx >= N) idx = idx - N;
    if (|rot) begin
      grant[idx] = 1'b1;
      grant_idx  = IW'(idx);
    end
  end

endmodule

// File: rtl/dff_rr_writer.sv
// Round-robin arbiter sharing one Dff register among N writers.
// Tracks last owner, pulses q_upd, counts accepted writes.
module dff_rr_writer
  import dff_rr_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 8,
  parameter int RESET_VAL = DEFAULT_RESET_VAL,
  parameter int CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic [N-1:0]           req_valid,
  input  logic [N*WIDTH-1:0]     req_data,
  output logic [N-1:0]           req_ready,
  output logic [WIDTH-1:0]       q,
  output logic [$clog2(N)-1:0]   q_owner,
  output logic                   q_upd,
  output logic [CNT_W-1:0]       upd_count
);

  localparam int IW = idx_w(N);
  localparam logic [WIDTH-1:0] RV = WIDTH'(RESET_VAL);

  typedef logic [IW-1:0] owner_t;

  owner_t           ptr;
  owner_t           gidx;
  owner_t           owner;
  logic [N-1:0]     grant;
  logic             xfer;
  logic [WIDTH-1:0] d;

  rr_grant #(.N(N), .IW(IW)) u_grant (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx)
  );

  // No grant during reset or clear, so no transfer can slip through.
  assign req_ready = (rst && !clr) ? grant : '0;
  assign xfer      = |req_ready;
  assign q_owner   = owner;

  always_comb begin
    d = q;
    unique case (1'b1)
      clr:     d = RV;
      xfer:    d = req_data[gidx*WIDTH +: WIDTH];
      default: d = q;
    endcase
  end

  Dff #(.WIDTH(WIDTH), .RESET_VAL(RV)) u_q (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .q   (q)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner     <= '0;
      q_upd     <= 1'b0;
      upd_count <= '0;
    end else begin
      q_upd <= xfer;
      if (clr) begin
        owner     <= '0;
        upd_count <= '0;
      end else if (xfer) begin
        owner <= gidx;
        if (upd_count != '1) upd_count <= upd_count + CNT_W'(1);
      end
    end
  end

endmodule
